// File: rtl/ws2812_frame_arbiter_pkg.sv
// Shared types and widths for the ws2812 frame arbiter: FSM states, colour/channel
// widths and the two-requester round-robin pick.
package ws2812_frame_arbiter_pkg;

   localparam int COLOR_W   = 24;
   localparam int CH_W      = 8;
   localparam int LED_NUM_W = 8;
   localparam int NUM_REQ   = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_STREAM  = 2'd2,
      ST_HOLDOFF = 2'd3
   } state_t;

   // On a tie the requester that was not served last wins.
   function automatic logic [NUM_REQ-1:0] pick_winner(input logic [NUM_REQ-1:0] req,
                                                      input logic               last);
      logic [NUM_REQ-1:0] win;
      win = '0;
      if (req == 2'b11)  win = last ? 2'b01 : 2'b10;
      else if (req[0])   win = 2'b01;
      else if (req[1])   win = 2'b10;
      return win;
   endfunction

endpackage

// File: rtl/ws2812_scale.sv
// Combinational global-brightness scaler: each 8-bit channel becomes
// (c * (bright + 1)) >> 8, so 255 is identity and 0 blanks the pixel.
module ws2812_scale
   import ws2812_frame_arbiter_pkg::*;
(
   input  logic [COLOR_W-1:0] i_rgb,
   input  logic [CH_W-1:0]    i_bright,
   output logic [COLOR_W-1:0] o_rgb
);

   logic [2*CH_W-1:0] w_mult;

   assign w_mult = (2*CH_W)'(i_bright) + (2*CH_W)'(1);

   for (genvar ch = 0; ch < COLOR_W/CH_W; ch++) begin : g_ch
      logic [2*CH_W-1:0] w_prod;
      // 255 * 256 still fits in 16 bits, so no overflow bit is needed.
      assign w_prod = (2*CH_W)'(i_rgb[ch*CH_W +: CH_W]) * w_mult;
      assign o_rgb[ch*CH_W +: CH_W] = CH_W'(w_prod >> CH_W);
   end

endmodule

// File: rtl/ws2812_frame_arbiter.sv
// Frame-granular round-robin arbiter feeding one ws2812 driver write port from two
// pixel sources, with per-frame brightness scaling and an inter-frame holdoff.
module ws2812_frame_arbiter
   import ws2812_frame_arbiter_pkg::*;
#(
   parameter int NUM_LEDS = 8,
   parameter int MIN_GAP  = 16
)
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         i_req,
   output logic [NUM_REQ-1:0]         o_grant,
   input  logic [NUM_REQ-1:0]         i_pix_valid,
   input  logic [NUM_REQ*COLOR_W-1:0] i_pix_data,
   output logic [NUM_REQ-1:0]         o_pix_ready,
   input  logic [CH_W-1:0]            i_brightness,
   output logic                       o_led_write,
   output logic [LED_NUM_W-1:0]       o_led_num,
   output logic [COLOR_W-1:0]         o_led_rgb,
   output logic                       o_busy,
   output logic                       o_frame_done,
   output logic                       o_frame_abort
);

   localparam logic [LED_NUM_W-1:0] LAST_IDX = LED_NUM_W'(NUM_LEDS - 1);
   localparam int                   GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
   // With no gap configured, frame exits fall straight back to arbitration.
   localparam state_t               EXIT_ST  = (MIN_GAP == 0) ? ST_IDLE : ST_HOLDOFF;

   state_t               r_state;
   logic [NUM_REQ-1:0]   r_grant;
   logic                 r_last;
   logic [LED_NUM_W-1:0] r_idx;
   logic [CH_W-1:0]      r_bright;
   logic [GAP_W-1:0]     r_gap;
   logic                 r_led_write;
   logic [LED_NUM_W-1:0] r_led_num;
   logic [COLOR_W-1:0]   r_led_rgb;
   logic                 r_frame_done;
   logic                 r_frame_abort;

   logic                 w_owner;
   logic                 w_owner_req;
   logic                 w_accept;
   logic [COLOR_W-1:0]   w_pixel;
   logic [COLOR_W-1:0]   w_scaled;

   assign w_owner     = r_grant[1];
   assign w_owner_req = |(i_req & r_grant);
   assign o_pix_ready = (r_state == ST_STREAM) ? r_grant : '0;
   assign w_accept    = |(i_pix_valid & o_pix_ready);
   assign w_pixel     = w_owner ? i_pix_data[2*COLOR_W-1:COLOR_W] : i_pix_data[COLOR_W-1:0];

   ws2812_scale u_scale (
      .i_rgb    (w_pixel),
      .i_bright (r_bright),
      .o_rgb    (w_scaled)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_grant       <= '0;
         r_last        <= 1'b1;
         r_idx         <= '0;
         r_bright      <= '0;
         r_gap         <= '0;
         r_led_write   <= 1'b0;
         r_led_num     <= '0;
         r_led_rgb     <= '0;
         r_frame_done  <= 1'b0;
         r_frame_abort <= 1'b0;
      end else begin
         r_led_write   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_abort <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (|i_req) begin
                  r_grant <= pick_winner(i_req, r_last);
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               r_bright <= i_brightness;
               r_idx    <= '0;
               r_state  <= ST_STREAM;
            end
            ST_STREAM: begin
               // An accept on the same cycle as a req drop still counts as a pixel.
               if (w_accept) begin
                  r_led_write <= 1'b1;
                  r_led_num   <= r_idx;
                  r_led_rgb   <= w_scaled;
                  r_idx       <= r_idx + 1'b1;
                  if (r_idx == LAST_IDX) begin
                     r_frame_done <= 1'b1;
                     r_last       <= w_owner;
                     r_grant      <= '0;
                     r_gap        <= '0;
                     r_state      <= EXIT_ST;
                  end
               end else if (!w_owner_req) begin
                  r_frame_abort <= 1'b1;
                  r_last        <= w_owner;
                  r_grant       <= '0;
                  r_gap         <= '0;
                  r_state       <= EXIT_ST;
               end
            end
            ST_HOLDOFF: begin
               if (r_gap == GAP_LAST) r_state <= ST_IDLE;
               else                   r_gap   <= r_gap + 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant       = r_grant;
   assign o_led_write   = r_led_write;
   assign o_led_num     = r_led_num;
   assign o_led_rgb     = r_led_rgb;
   assign o_busy        = (r_state != ST_IDLE);
   assign o_frame_done  = r_frame_done;
   assign o_frame_abort = r_frame_abort;

endmodule
